// File: rtl/regfile_multiport_pkg.sv
// Shared register-file types and default geometry, reused by the pipeline top level.
package regfile_multiport_pkg;

    typedef enum logic {
        StClear,
        StReady
    } rf_state_e;

    localparam int unsigned DefaultDataW = 32;
    localparam int unsigned DefaultAddrW = 5;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port with write-to-read bypass and hard-wired zero register.
module regfile_read_port
    import regfile_multiport_pkg::*;
#(
    parameter int unsigned DATA_W   = DefaultDataW,
    parameter int unsigned ADDR_W   = DefaultAddrW,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read_fire,
    input  logic [ADDR_W-1:0] read_reg,
    input  logic [DATA_W-1:0] array_data,
    input  logic              write_fire,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data
);

    logic [DATA_W-1:0] read_data_q, read_data_d;

    always_comb begin
        read_data_d = read_data_q;
        if (read_fire) begin
            // Zero register takes priority over the bypass path.
            if ((ZERO_REG != 0) && (read_reg == '0)) begin
                read_data_d = '0;
            end else if (write_fire && (write_reg == read_reg)) begin
                read_data_d = write_data;
            end else begin
                read_data_d = array_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_data_q <= '0;
        end else begin
            read_data_q <= read_data_d;
        end
    end

    assign read_data = read_data_q;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-read-port register file with a post-reset clear sequencer (one entry per cycle).
module regfile_multiport
    import regfile_multiport_pkg::*;
#(
    parameter int unsigned DATA_W   = DefaultDataW,
    parameter int unsigned ADDR_W   = DefaultAddrW,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        write_reg,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     read_en,
    input  logic [NUM_RD*ADDR_W-1:0] read_reg,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic                     read_valid,
    output logic                     busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              read_valid_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic ready;
    logic write_fire;
    logic read_fire;

    assign ready      = (state_q == StReady);
    assign write_fire = RegWrite && ready;
    assign read_fire  = read_en && ready;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            StClear: begin
                // Index wraps back to zero as the last entry is cleared.
                clr_idx_d = clr_idx_q + ADDR_W'(1);
                if (clr_idx_q == LastIdx) begin
                    state_d = StReady;
                end
            end
            StReady: state_d = StReady;
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StClear;
            clr_idx_q    <= '0;
            read_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            read_valid_q <= read_fire;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == StClear) begin
                mem_q[clr_idx_q] <= '0;
            end else if (write_fire && !((ZERO_REG != 0) && (write_reg == '0))) begin
                mem_q[write_reg] <= write_data;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_read_port (
            .clock      (clock),
            .reset      (reset),
            .read_fire  (read_fire),
            .read_reg   (read_reg[p*ADDR_W +: ADDR_W]),
            .array_data (mem_q[read_reg[p*ADDR_W +: ADDR_W]]),
            .write_fire (write_fire),
            .write_reg  (write_reg),
            .write_data (write_data),
            .read_data  (read_data[p*DATA_W +: DATA_W])
        );
    end

    assign read_valid = read_valid_q;
    assign busy       = (state_q == StClear);

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed and random stimulus against a cycle model of the register file, scoreboarded reads.
module tb_regfile_multiport;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          RegWrite = 1'b0;
    logic [AW-1:0] write_reg = '0;
    logic [DW-1:0] write_data = '0;
    logic          read_en = 1'b0;
    logic [2*AW-1:0] read_reg = '0;
    logic [2*DW-1:0] read_data;
    logic          read_valid;
    logic          busy;

    regfile_multiport dut (
        .clock      (clock),
        .reset      (reset),
        .RegWrite   (RegWrite),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_en    (read_en),
        .read_reg   (read_reg),
        .read_data  (read_data),
        .read_valid (read_valid),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          passed = 0;
    string       phase = "init";
    logic [DW-1:0] m_mem [32];
    logic        m_ready = 1'b0;
    int          m_cnt = 0;
    logic [2*DW-1:0] m_last = '0;
    logic [2*DW-1:0] sb [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s/%s: observed %h expected %h", phase, tag, obs, exp);
    endtask

    // Model evaluated on pre-edge inputs, then DUT outputs compared just after the edge.
    task automatic tick();
        logic            exp_v;
        logic [2*DW-1:0] exp_rd;
        logic [AW-1:0]   a;
        exp_v  = read_en && m_ready && !reset;
        exp_rd = '0;
        if (exp_v) begin
            for (int p = 0; p < 2; p++) begin
                a = read_reg[p*AW +: AW];
                if (a == 0) exp_rd[p*DW +: DW] = '0;
                else if (RegWrite && write_reg == a) exp_rd[p*DW +: DW] = write_data;
                else exp_rd[p*DW +: DW] = m_mem[a];
            end
            sb.push_back(exp_rd);
        end
        if (reset) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            sb.delete();
        end else if (!m_ready) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == 32) m_ready = 1'b1;
        end else if (RegWrite && write_reg != 0) begin
            m_mem[write_reg] = write_data;
        end
        @(posedge clock);
        #1;
        check("busy", 64'(busy), 64'(!m_ready));
        check("read_valid", 64'(read_valid), 64'(exp_v));
        if (reset) m_last = '0;
        else if (exp_v && sb.size() > 0) m_last = sb.pop_front();
        check("read_data", read_data, m_last);
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic re, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        RegWrite   = we;
        write_reg  = wa;
        write_data = wd;
        read_en    = re;
        read_reg   = {a1, a0};
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = 32'hBAD0_0000 + i;

        phase = "reset";
        reset = 1'b1;
        drive(1'b1, 5'd3, 32'h5, 1'b1, 5'd3, 5'd3);
        tick();
        tick();
        reset = 1'b0;

        // Writes and reads attempted throughout the clear must be ignored.
        phase = "clear";
        for (int i = 0; i < 32; i++) tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        tick();

        phase = "read_all";
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(2 * i), 5'(2 * i + 1));
            tick();
        end

        phase = "write_read";
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0);
        tick();

        phase = "bypass";
        drive(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 5'd7);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd5);
        tick();

        phase = "zero_reg";
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd7);
        tick();

        phase = "hold";
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd5);
        tick();
        tick();

        phase = "random";
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            tick();
        end

        phase = "reset_ready";
        drive(1'b1, 5'd9, 32'hAAAA, 1'b1, 5'd9, 5'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        phase = "reset_midclear";
        drive(1'b1, 5'd3, 32'h5, 1'b1, 5'd3, 5'd5);
        while (m_cnt < 10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        tick();

        phase = "post_clear";
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd9);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd7);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
